window_scan_ctrl: RTL
=====================

// Module: window_scan_ctrl
// PURPOSE
//  Upstream scan controller for the 3x3 buffer + hysteresis join stage. Walks a WIDTH x HEIGHT
//  8-bit image in serpentine order, fetches 3 new pixels per window step from pixel memory,
//  drives buffer_input/shift_enable/shift_direction, and strobes hysteresis_enable once per
//  interior centre pixel (x=1..WIDTH-2, y=1..HEIGHT-2), tagged with its coordinates.
// PARAMETERS
//  WIDTH   16  image columns (>=3)
//  HEIGHT  16  image rows (>=3)
//  ADDR_W  16  pixel memory address width; address = y*WIDTH + x (row base + x, no multiplier)
//  COORD_W 8   width of pix_x / pix_y
// PORTS
//  clk                input   1        clock, rising edge
//  n_rst              input   1        asynchronous active-low reset
//  start              input   1        begin scan; sampled in IDLE only
//  mem_read           output  1        read request, held until mem_ready
//  mem_addr           output  ADDR_W   read address, stable while mem_read=1
//  mem_rdata          input   8        read data, valid when mem_ready=1
//  mem_ready          input   1        read completes this cycle
//  buffer_input       output  8 x[0:2] registered new column/row for the 3x3 buffer
//  shift_enable       output  1        one-cycle shift pulse
//  shift_direction    output  2        00=right(new col at x+1),01=left(new col at x-1),10=down
//  hysteresis_enable  output  1        one-cycle evaluate strobe
//  pix_x, pix_y       output  COORD_W  centre coordinate of current evaluation
//  busy               output  1        high in any state except IDLE
//  done               output  1        one-cycle pulse after last evaluation
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0. Reset mid-scan aborts, no done pulse.
//  - States: IDLE -> FETCH -> SHIFT -> (FILL: FETCH | EVAL) ; EVAL -> FETCH | DONE ; DONE -> IDLE.
//  - FETCH: 3 sequential reads, k=0..2; read k captured into buffer_input[k] on mem_ready;
//    next read issues the following cycle. mem_ready low stalls, mem_read/mem_addr held.
//  - Horizontal step: new column x' at rows y-1,y,y+1 -> [0],[1],[2]. Down step: new row y+2
//    at columns cx-1,cx,cx+1 -> [0],[1],[2].
//  - SHIFT: shift_enable=1 one cycle with direction; buffer_input stable through SHIFT.
//  - Fill: columns 0,1,2 of rows 0..2 loaded with 3 right shifts, no EVAL until third.
//  - EVAL: hysteresis_enable=1 one cycle, pix_x/pix_y = centre; window already updated.
//  - Order: row 1 left->right to cx=WIDTH-2; down; leftwards to cx=1; down; ... ends when
//    last centre of row HEIGHT-2 evaluated -> DONE (done=1, busy=1 that cycle) -> IDLE.
//  - Exactly (WIDTH-2)*(HEIGHT-2) EVAL strobes per scan. start while busy ignored.
//  - mem_ready with mem_read=0 ignored. With mem_ready tied 1: 5 cycles per step.
// CONFIGURATION
//  WSC_STALL_CNT_EN defined: adds output stall_cnt[31:0], counts cycles mem_read=1 &
//  mem_ready=0 in current scan; cleared on accepted start and reset, saturates at max.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  canny_pkg: scan state enum, SHIFT_RIGHT/SHIFT_LEFT/SHIFT_DOWN 2-bit constants, PIX_W=8.
//  Sub-module scan_addr_gen: holds row base/cx/cy, direction flag, produces mem_addr per
//  fetch index and end-of-row/end-of-image flags; FSM and buffer regs stay in top.
// TESTING
//  1 W=H=3, mem_ready=1, start@cycle0 -> reads 1-3,5-7,9-11, shift right @4,8,12,
//    EVAL @13 at (1,1), done @14, 9 reads addr 0,3,6,1,4,7,2,5,8.
//  2 W=5,H=4 -> EVAL order (1,1),(2,1),(3,1),(3,2),(2,2),(1,2); shift dir 00,00,00,00,00,10,01,01,
//    10? no: second down none; total 6 EVAL, one done.
//  3 mem_ready low 4 cycles on 2nd read -> mem_addr/mem_read held, EVAL delayed 4 cycles,
//    stall_cnt=4 with WSC_STALL_CNT_EN.
//  4 n_rst low mid-FETCH -> all outputs 0 immediately, IDLE, no done; new start scans normally.
//  5 start pulses while busy -> ignored; EVAL count still (W-2)*(H-2), single done.
//  6 Pixel ramp mem[a]=a, W=H=4 -> at EVAL (2,1) buffer window rows {1,2,3},{5,6,7},{9,10,11}.

Source files
------------

// File: rtl/canny_pkg.sv
// Shared types and constants for the window scan controller and its address generator.
package canny_pkg;
    localparam int PIX_W = 8;

    localparam logic [1:0] SHIFT_RIGHT = 2'b00;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_DOWN  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_EVAL,
        ST_DONE
    } scan_state_t;
endpackage

// File: rtl/scan_addr_gen.sv
// Serpentine position tracker: window centre, step direction and the pixel address of
// the next fetch. Addresses are built from a running row base, so no multiplier is needed.
module scan_addr_gen
    import canny_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int HEIGHT  = 16,
    parameter int ADDR_W  = 16,
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               init,
    input  logic               fill_step,
    input  logic               step,
    input  logic               read_adv,
    output logic [ADDR_W-1:0]  addr,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    output logic [1:0]         sdir,
    output logic               row_end,
    output logic               img_end
);
    localparam logic [ADDR_W-1:0]  W_A    = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0]  W3_A   = ADDR_W'(3 * WIDTH);
    localparam logic [ADDR_W-1:0]  A_ONE  = ADDR_W'(1);
    localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);
    localparam logic [COORD_W-1:0] C_TWO  = COORD_W'(2);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 2);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 2);

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [COORD_W-1:0] x_new_q, x_new_d;
    logic [COORD_W-1:0] cx_q, cx_d;
    logic [COORD_W-1:0] cy_q, cy_d;
    logic               left_q, left_d;
    logic [1:0]         sdir_q, sdir_d;

    assign row_end = left_q ? (cx_q == C_ONE) : (cx_q == X_LAST);
    assign img_end = row_end && (cy_q == Y_LAST);

    always_comb begin
        addr_d     = addr_q;
        row_base_d = row_base_q;
        x_new_d    = x_new_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        left_d     = left_q;
        sdir_d     = sdir_q;
        if (init) begin
            addr_d     = '0;
            row_base_d = '0;
            x_new_d    = '0;
            cx_d       = C_ONE;
            cy_d       = C_ONE;
            left_d     = 1'b0;
            sdir_d     = SHIFT_RIGHT;
        end else if (fill_step) begin
            x_new_d = x_new_q + C_ONE;
            addr_d  = row_base_q + ADDR_W'(x_new_d);
        end else if (step) begin
            if (!row_end) begin
                sdir_d  = left_q ? SHIFT_LEFT : SHIFT_RIGHT;
                cx_d    = left_q ? (cx_q - C_ONE) : (cx_q + C_ONE);
                x_new_d = left_q ? (cx_q - C_TWO) : (cx_q + C_TWO);
                addr_d  = row_base_q + ADDR_W'(x_new_d);
            end else begin
                // New bottom row sits three rows below the current window top.
                sdir_d     = SHIFT_DOWN;
                cy_d       = cy_q + C_ONE;
                left_d     = !left_q;
                row_base_d = row_base_q + W_A;
                addr_d     = row_base_q + W3_A + ADDR_W'(cx_q) - A_ONE;
            end
        end else if (read_adv) begin
            addr_d = addr_q + ((sdir_q == SHIFT_DOWN) ? A_ONE : W_A);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_q     <= '0;
            row_base_q <= '0;
            x_new_q    <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            left_q     <= 1'b0;
            sdir_q     <= SHIFT_RIGHT;
        end else begin
            addr_q     <= addr_d;
            row_base_q <= row_base_d;
            x_new_q    <= x_new_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            left_q     <= left_d;
            sdir_q     <= sdir_d;
        end
    end

    assign addr = addr_q;
    assign cx   = cx_q;
    assign cy   = cy_q;
    assign sdir = sdir_q;
endmodule

// File: rtl/window_scan_ctrl.sv
// Serpentine 3x3 window scan controller: fetches pixels, drives the window buffer shifts and
// strobes evaluation per interior pixel. Define WSC_STALL_CNT_EN to add the stall_cnt output.
module window_scan_ctrl
    import canny_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int HEIGHT  = 16,
    parameter int ADDR_W  = 16,
    parameter int COORD_W = 8
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        start,
    output logic                        mem_read,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [PIX_W-1:0]            mem_rdata,
    input  logic                        mem_ready,
    output logic [0:2][PIX_W-1:0]       buffer_input,
    output logic                        shift_enable,
    output logic [1:0]                  shift_direction,
    output logic                        hysteresis_enable,
    output logic [COORD_W-1:0]          pix_x,
    output logic [COORD_W-1:0]          pix_y,
    output logic                        busy,
`ifdef WSC_STALL_CNT_EN
    output logic [31:0]                 stall_cnt,
`endif
    output logic                        done
);
    scan_state_t             state_q, state_d;
    logic [1:0]              k_q, k_d;
    logic [1:0]              fill_q, fill_d;
    logic [0:2][PIX_W-1:0]   buf_q, buf_d;
    logic                    init, fill_step, step, read_adv;
    logic [ADDR_W-1:0]       addr;
    logic [COORD_W-1:0]      cx, cy;
    logic [1:0]              sdir;
    logic                    row_end, img_end;

    scan_addr_gen #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .ADDR_W  (ADDR_W),
        .COORD_W (COORD_W)
    ) u_addr_gen (
        .clk       (clk),
        .n_rst     (n_rst),
        .init      (init),
        .fill_step (fill_step),
        .step      (step),
        .read_adv  (read_adv),
        .addr      (addr),
        .cx        (cx),
        .cy        (cy),
        .sdir      (sdir),
        .row_end   (row_end),
        .img_end   (img_end)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        fill_d    = fill_q;
        buf_d     = buf_q;
        init      = 1'b0;
        fill_step = 1'b0;
        step      = 1'b0;
        read_adv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    init    = 1'b1;
                    k_d     = '0;
                    fill_d  = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    buf_d[k_q] = mem_rdata;
                    if (k_q == 2'd2) begin
                        k_d     = '0;
                        state_d = ST_SHIFT;
                    end else begin
                        k_d      = k_q + 2'd1;
                        read_adv = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                // The first two shifts only prime the window; evaluation starts after the third.
                if (fill_q != 2'd2) begin
                    fill_d    = fill_q + 2'd1;
                    fill_step = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (img_end) begin
                    state_d = ST_DONE;
                end else begin
                    step    = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            fill_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            fill_q  <= fill_d;
            buf_q   <= buf_d;
        end
    end

    assign mem_read          = (state_q == ST_FETCH);
    assign mem_addr          = mem_read ? addr : '0;
    assign buffer_input      = buf_q;
    assign shift_enable      = (state_q == ST_SHIFT);
    assign shift_direction   = shift_enable ? sdir : 2'b00;
    assign hysteresis_enable = (state_q == ST_EVAL);
    assign pix_x             = hysteresis_enable ? cx : '0;
    assign pix_y             = hysteresis_enable ? cy : '0;
    assign busy              = (state_q != ST_IDLE);
    assign done              = (state_q == ST_DONE);

`ifdef WSC_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_IDLE) && start) begin
            stall_cnt_d = '0;
        end else if (mem_read && !mem_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule
